// File: rtl/btb_update_ctrl.sv
// BTB write-port owner: invalidate sweep, mispredict detect, update FIFO.
// Optional macro BTB_UPDATE_CTRL_STATS_EN adds stat_mispred/stat_drop counters.
module btb_update_ctrl #(
    parameter int INDEX_W    = 10,
    parameter int TAG_W      = 20,
    parameter int TGT_W      = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               upd_valid_E,
    input  logic [TAG_W-1:0]   upd_pc_E,
    input  logic               upd_taken_E,
    input  logic [TGT_W-1:0]   upd_target_E,
    input  logic               pred_hit_E,
    input  logic [TGT_W-1:0]   pred_target_E,
    input  logic               flush_req,
    output logic               mispredict_E,
    output logic [TGT_W-1:0]   redirect_pc_E,
    output logic               upd_ready,
    output logic               busy,
    output logic               btb_we,
    output logic [INDEX_W-1:0] btb_idx,
    output logic [TAG_W-1:0]   btb_tag,
    output logic [TGT_W-1:0]   btb_target,
    output logic               btb_valid
`ifdef BTB_UPDATE_CTRL_STATS_EN
    ,
    output logic [15:0]        stat_mispred,
    output logic [15:0]        stat_drop
`endif
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

    typedef enum logic {SWEEP, RUN} state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [INDEX_W-1:0] r_sidx;
    logic               w_sweep_wr;
    logic               w_pop;

    logic [TAG_W-1:0]   r_q_tag [FIFO_DEPTH];
    logic [TGT_W-1:0]   r_q_tgt [FIFO_DEPTH];
    logic               r_q_vld [FIFO_DEPTH];
    logic [PW-1:0]      r_wp;
    logic [PW-1:0]      r_rp;
    logic [PW:0]        r_cnt;

    logic               w_full;
    logic               w_mp;
    logic [TGT_W-1:0]   w_redir;
    logic [TGT_W-1:0]   w_pc_ext;
    logic               w_enq;
    logic               w_drop;

    logic               r_we;
    logic [INDEX_W-1:0] r_idx;
    logic [TAG_W-1:0]   r_tag;
    logic [TGT_W-1:0]   r_tgt;
    logic               r_vld;

    assign w_pc_ext = TGT_W'(upd_pc_E);
    assign w_full   = (r_cnt == FULL_CNT);

    // Resolve the execute-stage outcome against the fetch-time prediction
    always_comb begin
        w_mp    = 1'b0;
        w_redir = '0;
        if (upd_valid_E) begin
            if (upd_taken_E) begin
                if (!pred_hit_E || (pred_target_E != upd_target_E)) begin
                    w_mp    = 1'b1;
                    w_redir = upd_target_E;
                end
            end else if (pred_hit_E) begin
                w_mp    = 1'b1;
                w_redir = w_pc_ext + TGT_W'(4);
            end
        end
    end

    assign mispredict_E  = w_mp;
    assign redirect_pc_E = w_redir;

    // Flush wins over enqueue; a full FIFO rejects even if it pops now
    assign w_enq  = w_mp & ~flush_req & ~w_full;
    assign w_drop = w_mp & (flush_req | w_full);

    // Next state and write-port arbitration: sweep beats drain
    always_comb begin
        w_state_nx = r_state;
        w_sweep_wr = 1'b0;
        w_pop      = 1'b0;
        if (flush_req) begin
            w_state_nx = SWEEP;
        end else begin
            unique case (r_state)
                SWEEP: begin
                    w_sweep_wr = 1'b1;
                    if (r_sidx == '1) begin
                        w_state_nx = RUN;
                    end
                end
                RUN: begin
                    w_pop = (r_cnt != '0);
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= SWEEP;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Sweep index restarts from zero on reset or flush
    always_ff @(posedge clk) begin
        if (!rst_n || flush_req) begin
            r_sidx <= '0;
        end else if (w_sweep_wr) begin
            r_sidx <= r_sidx + 1'b1;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst_n || flush_req) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_enq) begin
                r_wp <= (r_wp == PW'(FIFO_DEPTH-1)) ? '0 : r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= (r_rp == PW'(FIFO_DEPTH-1)) ? '0 : r_rp + 1'b1;
            end
            unique case ({w_enq, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // FIFO storage; not-taken corrections store an invalid entry
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_q_tag[r_wp] <= upd_pc_E;
            r_q_tgt[r_wp] <= upd_taken_E ? upd_target_E : '0;
            r_q_vld[r_wp] <= upd_taken_E;
        end
    end

    // Registered BTB write port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_we  <= 1'b0;
            r_idx <= '0;
            r_tag <= '0;
            r_tgt <= '0;
            r_vld <= 1'b0;
        end else if (w_sweep_wr) begin
            r_we  <= 1'b1;
            r_idx <= r_sidx;
            r_tag <= '0;
            r_tgt <= '0;
            r_vld <= 1'b0;
        end else if (w_pop) begin
            r_we  <= 1'b1;
            r_idx <= r_q_tag[r_rp][INDEX_W-1:0];
            r_tag <= r_q_tag[r_rp];
            r_tgt <= r_q_tgt[r_rp];
            r_vld <= r_q_vld[r_rp];
        end else begin
            r_we  <= 1'b0;
        end
    end

    assign btb_we     = r_we;
    assign btb_idx    = r_idx;
    assign btb_tag    = r_tag;
    assign btb_target = r_tgt;
    assign btb_valid  = r_vld;
    assign busy       = (r_state == SWEEP);
    assign upd_ready  = ~w_full;

`ifdef BTB_UPDATE_CTRL_STATS_EN
    logic [15:0] r_stat_mp;
    logic [15:0] r_stat_drop;

    // Saturating event counters; only reset clears them
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_mp   <= '0;
            r_stat_drop <= '0;
        end else begin
            if (w_mp && (r_stat_mp != 16'hFFFF)) begin
                r_stat_mp <= r_stat_mp + 1'b1;
            end
            if (w_drop && (r_stat_drop != 16'hFFFF)) begin
                r_stat_drop <= r_stat_drop + 1'b1;
            end
        end
    end

    assign stat_mispred = r_stat_mp;
    assign stat_drop    = r_stat_drop;
`endif

endmodule
